// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared multi-cycle ALU, one op in flight.
// Optional macro ALU_ARB_OPCHECK_EN: illegal opcodes bypass the ALU and answer with rsp_err.
module alu_arbiter #(
  parameter int ALU_LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [3:0]  req0_op,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [3:0]  req1_op,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic [3:0]  alu_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_zero,
  output logic        rsp_id,
  output logic        rsp_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam int CW = $clog2(ALU_LAT + 2);

  logic [1:0]    state_q, state_d;
  logic          last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    alu_op_q, alu_op_d;
  logic [31:0]   alu_a_q, alu_a_d;
  logic [31:0]   alu_b_q, alu_b_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [31:0]   rsp_data_q, rsp_data_d;
  logic          rsp_zero_q, rsp_zero_d;
  logic          rsp_id_q, rsp_id_d;

  logic          gnt_id;
  logic          xfer;
  logic [3:0]    gnt_op;
  logic [31:0]   gnt_a, gnt_b;
  logic          op_bad;

  // With both pending, serve whoever was not served last; otherwise whoever is valid.
  always_comb begin
    if (req0_valid && req1_valid) gnt_id = ~last_q;
    else                          gnt_id = req1_valid;
  end

  assign req0_ready = rst_n && (state_q == S_IDLE) && req0_valid && !gnt_id;
  assign req1_ready = rst_n && (state_q == S_IDLE) && req1_valid && gnt_id;
  assign xfer       = req0_ready || req1_ready;
  assign gnt_op     = gnt_id ? req1_op : req0_op;
  assign gnt_a      = gnt_id ? req1_a  : req0_a;
  assign gnt_b      = gnt_id ? req1_b  : req0_b;

`ifdef ALU_ARB_OPCHECK_EN
  logic rsp_err_q;

  always_comb begin
    case (gnt_op)
      4'b0000, 4'b0010, 4'b0100, 4'b0101,
      4'b0110, 4'b0111, 4'b1010: op_bad = 1'b0;
      default:                   op_bad = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n)    rsp_err_q <= 1'b0;
    else if (xfer) rsp_err_q <= op_bad;
  end

  assign rsp_err = rsp_err_q;
`else
  assign op_bad  = 1'b0;
  assign rsp_err = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    alu_op_d    = alu_op_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_zero_d  = rsp_zero_q;
    rsp_id_d    = rsp_id_q;
    case (state_q)
      S_IDLE: begin
        if (xfer) begin
          last_d   = gnt_id;
          rsp_id_d = gnt_id;
          if (op_bad) begin
            // Rejected op never reaches the ALU; answer immediately.
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_data_d  = 32'd0;
            rsp_zero_d  = 1'b1;
          end else begin
            state_d  = S_EXEC;
            cnt_d    = '0;
            alu_op_d = gnt_op;
            alu_a_d  = gnt_a;
            alu_b_d  = gnt_b;
          end
        end
      end
      S_EXEC: begin
        if (cnt_q == CW'(ALU_LAT)) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_data_d  = alu_result;
          rsp_zero_d  = alu_zero;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      last_q      <= 1'b1;
      cnt_q       <= '0;
      alu_op_q    <= 4'b0000;
      alu_a_q     <= 32'd0;
      alu_b_q     <= 32'd0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 32'd0;
      rsp_zero_q  <= 1'b0;
      rsp_id_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      alu_op_q    <= alu_op_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_zero_q  <= rsp_zero_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  assign alu_op    = alu_op_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_zero  = rsp_zero_q;
  assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural ALU with ALU_LAT register stages, scoreboard of expected responses.
module tb_alu_arbiter;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0]  req0_op, req1_op, alu_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b, alu_a, alu_b, alu_result, rsp_data;
  logic        alu_zero, rsp_valid, rsp_ready, rsp_zero, rsp_id, rsp_err;

  typedef struct {
    logic [31:0] data;
    logic        zero;
    logic        id;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.ALU_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_zero(rsp_zero),
    .rsp_id(rsp_id), .rsp_err(rsp_err)
  );

  function automatic logic [32:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    case (op)
      4'b0000: r = a + b;
      4'b0010: r = a - b;
      4'b0100: r = a & b;
      4'b0101: r = a | b;
      4'b0110: r = a ^ b;
      4'b0111: r = ~(a | b);
      4'b1010: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: r = 32'd0;
    endcase
    return {(r == 32'd0), r};
  endfunction

  // Shared ALU model: result valid LAT edges after its inputs change.
  logic [32:0] alu_pipe [LAT];
  always @(posedge clk) begin
    alu_pipe[0] <= ref_alu(alu_op, alu_a, alu_b);
    for (int i = 1; i < LAT; i++) alu_pipe[i] <= alu_pipe[i-1];
  end
  assign alu_result = alu_pipe[LAT-1][31:0];
  assign alu_zero   = alu_pipe[LAT-1][32];

  // Present one request and hold it until accepted; returns at transfer edge + 1.
  task automatic send(input logic id, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      output bit timeout);
    int n = 0;
    @(negedge clk);
    if (id) begin req1_op = op; req1_a = a; req1_b = b; req1_valid = 1'b1; end
    else    begin req0_op = op; req0_a = a; req0_b = b; req0_valid = 1'b1; end
    #1;
    while (!(id ? req1_ready : req0_ready) && n < 40) begin
      @(negedge clk); #1; n++;
    end
    timeout = !(id ? req1_ready : req0_ready);
    if (!timeout) begin
      @(posedge clk); #1;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  // Called at transfer edge + 1; edges counts the transfer edge as edge 1.
  task automatic collect(output logic [31:0] d, output logic z, output logic id, output logic err,
                         output int edges);
    edges = 1;
    while (!rsp_valid && edges < 40) begin
      @(posedge clk); #1; edges++;
    end
    d = rsp_data; z = rsp_zero; id = rsp_id; err = rsp_err;
    $display("txn id=%0d data=%h zero=%b err=%b valid=%b edges=%0d", id, d, z, err, rsp_valid, edges);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      failures++; $display("FAIL reset_ready: got %b%b want 00", req0_ready, req1_ready);
    end
    checks++;
    if (alu_op !== 4'b0 || alu_a !== 32'd0 || alu_b !== 32'd0) begin
      failures++; $display("FAIL reset_alu: got op=%h a=%h b=%h want 0", alu_op, alu_a, alu_b);
    end
    checks++;
    if ({rsp_valid, rsp_zero, rsp_id, rsp_err} !== 4'b0 || rsp_data !== 32'd0) begin
      failures++; $display("FAIL reset_rsp: got v=%b d=%h z=%b id=%b e=%b want 0", rsp_valid, rsp_data, rsp_zero, rsp_id, rsp_err);
    end
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    bit to; logic [31:0] d; logic z, id, e; int edges; exp_t x;
    sb.push_back('{data: 32'd12, zero: 1'b0, id: 1'b0, err: 1'b0});
    send(1'b0, 4'b0000, 32'd5, 32'd7, to);
    checks++;
    if (to) begin failures++; $display("FAIL single_grant: got no ready want ready"); return; end
    collect(d, z, id, e, edges);
    x = sb.pop_front();
    checks++;
    if (d !== x.data || z !== x.zero || id !== x.id || e !== x.err) begin
      failures++; $display("FAIL single_rsp: got %h/%b/%b/%b want %h/%b/%b/%b", d, z, id, e, x.data, x.zero, x.id, x.err);
    end
    checks++;
    if (edges !== LAT + 2) begin failures++; $display("FAIL single_latency: got %0d want %0d", edges, LAT + 2); end
  endtask

  task automatic test_contention();
    logic [31:0] d; logic z, id, e; int edges, n; exp_t x; logic want;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    req0_op = 4'b0010; req0_a = 32'd9; req0_b = 32'd9;
    req1_op = 4'b1010; req1_a = 32'd3; req1_b = 32'd4;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      want = k[0];
      if (want) sb.push_back('{data: 32'd1, zero: 1'b0, id: 1'b1, err: 1'b0});
      else      sb.push_back('{data: 32'd0, zero: 1'b1, id: 1'b0, err: 1'b0});
      #1;
      n = 0;
      while (!(req0_ready || req1_ready) && n < 40) begin @(negedge clk); #1; n++; end
      checks++;
      if (req0_ready !== !want || req1_ready !== want) begin
        failures++; $display("FAIL contention_grant%0d: got ready=%b%b want id %0d", k, req1_ready, req0_ready, want);
      end
      @(posedge clk); #1;
      collect(d, z, id, e, edges);
      x = sb.pop_front();
      checks++;
      if (d !== x.data || z !== x.zero || id !== x.id || e !== x.err || edges !== LAT + 2) begin
        failures++; $display("FAIL contention_rsp%0d: got %h/%b/%b/%b/%0d want %h/%b/%b/%b/%0d", k, d, z, id, e, edges, x.data, x.zero, x.id, x.err, LAT + 2);
      end
      checks++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        failures++; $display("FAIL contention_resp_ready%0d: got %b%b want 00", k, req1_ready, req0_ready);
      end
      @(posedge clk); #1;
      checks++;
      if ((want ? req0_ready : req1_ready) !== 1'b1) begin
        failures++; $display("FAIL contention_next_ready%0d: got %b%b want id %0d", k, req1_ready, req0_ready, !want);
      end
      if (k == 3) begin req0_valid = 1'b0; req1_valid = 1'b0; end
    end
  endtask

  task automatic test_backpressure();
    bit to; logic [31:0] d; logic z, id, e; int edges; exp_t x;
    rsp_ready = 1'b0;
    sb.push_back('{data: 32'h0F0F0F0F, zero: 1'b0, id: 1'b1, err: 1'b0});
    send(1'b1, 4'b0110, 32'hF0F0F0F0, 32'hFFFFFFFF, to);
    checks++;
    if (to) begin failures++; $display("FAIL bp_grant: got no ready want ready"); rsp_ready = 1'b1; return; end
    collect(d, z, id, e, edges);
    x = sb.pop_front();
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== x.data || rsp_zero !== x.zero || rsp_id !== x.id || rsp_err !== x.err) begin
        failures++; $display("FAIL bp_hold%0d: got v=%b %h/%b/%b/%b want v=1 %h/%b/%b/%b", c, rsp_valid, rsp_data, rsp_zero, rsp_id, rsp_err, x.data, x.zero, x.id, x.err);
      end
      checks++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || alu_op !== 4'b0110 || alu_a !== 32'hF0F0F0F0 || alu_b !== 32'hFFFFFFFF) begin
        failures++; $display("FAIL bp_quiet%0d: got ready=%b%b alu=%h/%h/%h want 00 6/f0f0f0f0/ffffffff", c, req1_ready, req0_ready, alu_op, alu_a, alu_b);
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b0) begin failures++; $display("FAIL bp_release: got rsp_valid=%b want 0", rsp_valid); end
  endtask

  task automatic test_reset_mid_exec();
    bit to; bit seen = 0;
    send(1'b0, 4'b0000, 32'd1, 32'd1, to);
    checks++;
    if (to) begin failures++; $display("FAIL rst_exec_grant: got no ready want ready"); return; end
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_data !== 32'd0 || rsp_zero !== 1'b0 || rsp_id !== 1'b0 || rsp_err !== 1'b0 ||
        alu_op !== 4'b0 || alu_a !== 32'd0 || alu_b !== 32'd0) begin
      failures++; $display("FAIL rst_exec_outputs: got v=%b d=%h z=%b alu=%h/%h/%h want all 0", rsp_valid, rsp_data, rsp_zero, alu_op, alu_a, alu_b);
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (LAT + 6) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) seen = 1;
    end
    checks++;
    if (seen) begin failures++; $display("FAIL rst_exec_no_rsp: got rsp_valid pulse want none"); end
  endtask

  task automatic test_drop();
    bit to; logic [31:0] d; logic z, id, e; int edges; exp_t x; bit seen = 0;
    sb.push_back('{data: 32'hFFFFFFF0, zero: 1'b0, id: 1'b0, err: 1'b0});
    send(1'b0, 4'b0111, 32'h5, 32'hA, to);
    checks++;
    if (to) begin failures++; $display("FAIL drop_grant: got no ready want ready"); return; end
    @(negedge clk); req1_op = 4'b0000; req1_a = 32'd100; req1_b = 32'd1; req1_valid = 1'b1;
    @(negedge clk); req1_valid = 1'b0;
    @(posedge clk); #1;
    collect(d, z, id, e, edges);
    x = sb.pop_front();
    checks++;
    if (d !== x.data || z !== x.zero || id !== x.id || e !== x.err) begin
      failures++; $display("FAIL drop_rsp: got %h/%b/%b/%b want %h/%b/%b/%b", d, z, id, e, x.data, x.zero, x.id, x.err);
    end
    @(posedge clk);
    repeat (LAT + 6) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) seen = 1;
    end
    checks++;
    if (seen) begin failures++; $display("FAIL drop_no_rsp: got extra response want none"); end
  endtask

  task automatic test_illegal();
    bit to; logic [31:0] d; logic z, id, e; int edges; exp_t x; int want_edges; logic [3:0] want_op;
    sb.push_back('{data: 32'h0F, zero: 1'b0, id: 1'b1, err: 1'b0});
    send(1'b1, 4'b0100, 32'hFF, 32'h0F, to);
    collect(d, z, id, e, edges);
    x = sb.pop_front();
    checks++;
    if (to || d !== x.data || id !== x.id) begin
      failures++; $display("FAIL illegal_pre: got %h/%b want %h/%b", d, id, x.data, x.id);
    end
`ifdef ALU_ARB_OPCHECK_EN
    sb.push_back('{data: 32'd0, zero: 1'b1, id: 1'b1, err: 1'b1});
    want_edges = 1;
    want_op = 4'b0100;
`else
    sb.push_back('{data: 32'd0, zero: 1'b1, id: 1'b1, err: 1'b0});
    want_edges = LAT + 2;
    want_op = 4'b1111;
`endif
    send(1'b1, 4'b1111, 32'd8, 32'd9, to);
    checks++;
    if (to) begin failures++; $display("FAIL illegal_grant: got no ready want ready"); return; end
    collect(d, z, id, e, edges);
    x = sb.pop_front();
    checks++;
    if (d !== x.data || z !== x.zero || id !== x.id || e !== x.err || edges !== want_edges) begin
      failures++; $display("FAIL illegal_rsp: got %h/%b/%b/%b/%0d want %h/%b/%b/%b/%0d", d, z, id, e, edges, x.data, x.zero, x.id, x.err, want_edges);
    end
    checks++;
    if (alu_op !== want_op) begin failures++; $display("FAIL illegal_alu_op: got %h want %h", alu_op, want_op); end
  endtask

  task automatic test_random();
    bit to; logic [31:0] d, a, b; logic z, id, e, who; int edges; exp_t x; logic [32:0] r;
    logic [3:0] ops [7] = '{4'b0000, 4'b0010, 4'b0100, 4'b0101, 4'b0110, 4'b0111, 4'b1010};
    logic [3:0] op;
    for (int k = 0; k < 8; k++) begin
      op = ops[$urandom_range(0, 6)];
      a = $urandom; b = (k == 3) ? a : $urandom;
      who = 1'($urandom_range(0, 1));
      r = ref_alu(op, a, b);
      sb.push_back('{data: r[31:0], zero: r[32], id: who, err: 1'b0});
      send(who, op, a, b, to);
      checks++;
      if (to) begin failures++; $display("FAIL random_grant%0d: got no ready want ready", k); return; end
      collect(d, z, id, e, edges);
      x = sb.pop_front();
      checks++;
      if (d !== x.data || z !== x.zero || id !== x.id || e !== x.err || edges !== LAT + 2) begin
        failures++; $display("FAIL random_rsp%0d: op=%h got %h/%b/%b/%b/%0d want %h/%b/%b/%b/%0d", k, op, d, z, id, e, edges, x.data, x.zero, x.id, x.err, LAT + 2);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; rsp_ready = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_op = '0; req0_a = '0; req0_b = '0;
    req1_op = '0; req1_a = '0; req1_b = '0;
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_reset_mid_exec();
    test_drop();
    test_illegal();
    test_random();
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
